// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator for a raster-order pixel stream.
// Two line buffers hold the previous two rows; a 3x3 register window shifts
// left on every accepted pixel and presents nine taps with a valid strobe
// whenever the newest pixel completes a full neighbourhood (no padding).
module window_gen_3x3 #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDHT-1:0] Data_Out0,
    output logic [DATA_WIDHT-1:0] Data_Out1,
    output logic [DATA_WIDHT-1:0] Data_Out2,
    output logic [DATA_WIDHT-1:0] Data_Out3,
    output logic [DATA_WIDHT-1:0] Data_Out4,
    output logic [DATA_WIDHT-1:0] Data_Out5,
    output logic [DATA_WIDHT-1:0] Data_Out6,
    output logic [DATA_WIDHT-1:0] Data_Out7,
    output logic [DATA_WIDHT-1:0] Data_Out8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Position of the next pixel to be accepted.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb0 = previous row, lb1 = row before that, both indexed by column.
    logic [DATA_WIDHT-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDHT-1:0] lb1 [IMG_WIDTH];

    // Row-major window, index 0 = top-left, 8 = bottom-right (newest).
    logic [DATA_WIDHT-1:0] win [9];

    logic col_last;
    logic row_last;
    logic win_ok;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    // Windows with col < 2 mix in taps from the previous row, and rows 0-1
    // lack a full neighbourhood (or hold the previous frame), so only the
    // interior positions are flagged.
    assign win_ok   = (row >= ROW_TWO) && (col >= COL_TWO);

    // Raster position counters: column wraps into row, row wraps into frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (Valid_In) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers age one row per pixel; contents survive reset and frames.
    always_ff @(posedge clk) begin
        if (Valid_In) begin
            lb1[col] <= lb0[col];
            lb0[col] <= Data_In;
        end
    end

    // Window shifts left and loads the new right-hand column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else if (Valid_In) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1[col];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0[col];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= Data_In;
        end
    end

    // Single-cycle strobes for a complete window and for the frame's last window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= Valid_In && win_ok;
            Frame_Done <= Valid_In && row_last && col_last;
        end
    end

    assign Data_Out0 = win[0];
    assign Data_Out1 = win[1];
    assign Data_Out2 = win[2];
    assign Data_Out3 = win[3];
    assign Data_Out4 = win[4];
    assign Data_Out5 = win[5];
    assign Data_Out6 = win[6];
    assign Data_Out7 = win[7];
    assign Data_Out8 = win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3: a 4x4 instance for the small-image
// scenarios and a default 28x28 instance for transparency and window count.
module tb_window_gen_3x3;

    localparam int DW = 32;

    typedef struct packed {
        logic             v;
        logic             fd;
        logic             chk;
        logic [8:0][31:0] t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          vin;
    logic [DW-1:0] din;

    logic [DW-1:0] s_do [9];
    logic          s_vo, s_fd;
    logic [DW-1:0] d_do [9];
    logic          d_vo, d_fd;

    int checks = 0;
    int errors = 0;

    exp_t q_s[$];
    exp_t q_d[$];
    exp_t last_s, last_d;
    int   mr_s, mc_s, mr_d, mc_d;
    logic [31:0] img_s [4][4];
    logic [31:0] img_d [28][28];

    always #5 clk = ~clk;

    window_gen_3x3 #(.DATA_WIDHT(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_s (
        .clk(clk), .rst(rst), .Data_In(din), .Valid_In(vin),
        .Data_Out0(s_do[0]), .Data_Out1(s_do[1]), .Data_Out2(s_do[2]),
        .Data_Out3(s_do[3]), .Data_Out4(s_do[4]), .Data_Out5(s_do[5]),
        .Data_Out6(s_do[6]), .Data_Out7(s_do[7]), .Data_Out8(s_do[8]),
        .Valid_Out(s_vo), .Frame_Done(s_fd)
    );

    window_gen_3x3 dut_d (
        .clk(clk), .rst(rst), .Data_In(din), .Valid_In(vin),
        .Data_Out0(d_do[0]), .Data_Out1(d_do[1]), .Data_Out2(d_do[2]),
        .Data_Out3(d_do[3]), .Data_Out4(d_do[4]), .Data_Out5(d_do[5]),
        .Data_Out6(d_do[6]), .Data_Out7(d_do[7]), .Data_Out8(d_do[8]),
        .Valid_Out(d_vo), .Frame_Done(d_fd)
    );

    // Reference model: windows are cut straight out of a stored image.
    task automatic model(input logic sel, input logic [31:0] px, output exp_t e);
        int w = sel ? 28 : 4;
        int h = sel ? 28 : 4;
        int r = sel ? mr_d : mr_s;
        int c = sel ? mc_d : mc_s;
        e = '0;
        if (sel) img_d[r][c] = px; else img_s[r][c] = px;
        e.v   = (r >= 2) && (c >= 2);
        e.fd  = (r == h - 1) && (c == w - 1);
        e.chk = e.v;
        if (e.v)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.t[i*3+j] = sel ? img_d[r-2+i][c-2+j] : img_s[r-2+i][c-2+j];
        c++;
        if (c == w) begin
            c = 0;
            r = (r == h - 1) ? 0 : r + 1;
        end
        if (sel) begin mr_d = r; mc_d = c; end
        else     begin mr_s = r; mc_s = c; end
    endtask

    task automatic init_model();
        mr_s = 0; mc_s = 0; mr_d = 0; mc_d = 0;
        last_s = '0; last_s.chk = 1'b1;
        last_d = '0; last_d.chk = 1'b1;
        q_s.delete();
        q_d.delete();
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rise.
    task automatic step(input logic sel, input logic v, input logic [31:0] px,
                        output exp_t want, output logic ov, output logic ofd,
                        output logic [8:0][31:0] ot);
        exp_t e;
        @(negedge clk);
        vin = v;
        din = px;
        if (v) model(sel, px, e);
        else begin
            e = sel ? last_d : last_s;
            e.v = 1'b0;
            e.fd = 1'b0;
        end
        if (sel) begin last_d = e; q_d.push_back(e); end
        else     begin last_s = e; q_s.push_back(e); end
        @(posedge clk);
        #1;
        if (sel) want = q_d.pop_front(); else want = q_s.pop_front();
        ov  = sel ? d_vo : s_vo;
        ofd = sel ? d_fd : s_fd;
        for (int i = 0; i < 9; i++) ot[i] = sel ? d_do[i] : s_do[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        init_model();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s_vo !== 1'b0 || s_fd !== 1'b0 || d_vo !== 1'b0 || d_fd !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b%b%b%b want 0000", s_vo, s_fd, d_vo, d_fd);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (s_do[i] !== '0 || d_do[i] !== '0) begin
                errors++;
                $display("FAIL reset_tap%0d got %h/%h want 0", i, s_do[i], d_do[i]);
            end
        end
        rst = 1'b0;
        init_model();
    endtask

    task automatic test_continuous();
        exp_t want; logic ov, ofd; logic [8:0][31:0] ot;
        int nv = 0;
        int first[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int lastw[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 32'(k), want, ov, ofd, ot);
            if (ov === 1'b1) nv++;
            checks++;
            if (ov !== want.v || ofd !== want.fd) begin
                errors++;
                $display("FAIL cont_strobe k=%0d got v=%b fd=%b want v=%b fd=%b", k, ov, ofd, want.v, want.fd);
            end
            if (want.chk) begin
                checks++;
                if (ot !== want.t) begin
                    errors++;
                    $display("FAIL cont_taps k=%0d got %h want %h", k, ot, want.t);
                end
            end
            if (k == 10 || k == 15) begin
                for (int i = 0; i < 9; i++) begin
                    checks++;
                    if (ot[i] !== 32'(k == 10 ? first[i] : lastw[i])) begin
                        errors++;
                        $display("FAIL cont_window k=%0d tap%0d got %h want %h", k, i, ot[i],
                                 32'(k == 10 ? first[i] : lastw[i]));
                    end
                end
            end
        end
        checks++;
        if (nv != 4) begin
            errors++;
            $display("FAIL cont_count got %0d want 4", nv);
        end
    endtask

    task automatic test_gapped();
        exp_t want; logic ov, ofd; logic [8:0][31:0] ot;
        int nv = 0;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            step(1'b0, ~k[0], (k[0] ? 32'hdead_beef : 32'(k / 2)), want, ov, ofd, ot);
            if (ov === 1'b1) nv++;
            checks++;
            if (ov !== want.v || ofd !== want.fd) begin
                errors++;
                $display("FAIL gap_strobe k=%0d got v=%b fd=%b want v=%b fd=%b", k, ov, ofd, want.v, want.fd);
            end
            if (want.chk) begin
                checks++;
                if (ot !== want.t) begin
                    errors++;
                    $display("FAIL gap_taps k=%0d got %h want %h", k, ot, want.t);
                end
            end
        end
        checks++;
        if (nv != 4) begin
            errors++;
            $display("FAIL gap_count got %0d want 4", nv);
        end
    endtask

    task automatic test_row_wrap();
        exp_t want; logic ov, ofd; logic [8:0][31:0] ot;
        int w11[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        do_reset();
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 1'b1, 32'(k), want, ov, ofd, ot);
            if (k == 11) begin
                checks++;
                if (ov !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_valid11 got %b want 1", ov);
                end
                for (int i = 0; i < 9; i++) begin
                    checks++;
                    if (ot[i] !== 32'(w11[i])) begin
                        errors++;
                        $display("FAIL wrap_tap%0d got %h want %h", i, ot[i], 32'(w11[i]));
                    end
                end
            end
            if (k == 12 || k == 13) begin
                checks++;
                if (ov !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_invalid k=%0d got %b want 0", k, ov);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t want; logic ov, ofd; logic [8:0][31:0] ot;
        int nv = 0, nfd = 0;
        int w26[9] = '{16, 17, 18, 20, 21, 22, 24, 25, 26};
        do_reset();
        for (int k = 0; k < 32; k++) begin
            step(1'b0, 1'b1, 32'(k), want, ov, ofd, ot);
            if (ov === 1'b1) nv++;
            if (ofd === 1'b1) nfd++;
            checks++;
            if (ov !== want.v || ofd !== want.fd) begin
                errors++;
                $display("FAIL b2b_strobe k=%0d got v=%b fd=%b want v=%b fd=%b", k, ov, ofd, want.v, want.fd);
            end
            if (want.chk) begin
                checks++;
                if (ot !== want.t) begin
                    errors++;
                    $display("FAIL b2b_taps k=%0d got %h want %h", k, ot, want.t);
                end
            end
            if (k == 26) begin
                for (int i = 0; i < 9; i++) begin
                    checks++;
                    if (ot[i] !== 32'(w26[i])) begin
                        errors++;
                        $display("FAIL b2b_first2 tap%0d got %h want %h", i, ot[i], 32'(w26[i]));
                    end
                end
            end
        end
        checks++;
        if (nv != 8 || nfd != 2) begin
            errors++;
            $display("FAIL b2b_counts got v=%0d fd=%0d want v=8 fd=2", nv, nfd);
        end
    endtask

    task automatic test_reset_mid();
        exp_t want; logic ov, ofd; logic [8:0][31:0] ot;
        int nv = 0;
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 32'(k + 100), want, ov, ofd, ot);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (s_vo !== 1'b0 || s_fd !== 1'b0) begin
            errors++;
            $display("FAIL mid_strobes got v=%b fd=%b want 0 0", s_vo, s_fd);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (s_do[i] !== '0) begin
                errors++;
                $display("FAIL mid_tap%0d got %h want 0", i, s_do[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        vin = 1'b0;
        init_model();
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 32'(k), want, ov, ofd, ot);
            if (ov === 1'b1) nv++;
            checks++;
            if (ov !== want.v || ofd !== want.fd) begin
                errors++;
                $display("FAIL mid_strobe k=%0d got v=%b fd=%b want v=%b fd=%b", k, ov, ofd, want.v, want.fd);
            end
            if (want.chk) begin
                checks++;
                if (ot !== want.t) begin
                    errors++;
                    $display("FAIL mid_taps k=%0d got %h want %h", k, ot, want.t);
                end
            end
        end
        checks++;
        if (nv != 4) begin
            errors++;
            $display("FAIL mid_count got %0d want 4", nv);
        end
    endtask

    task automatic test_transparency();
        exp_t want; logic ov, ofd; logic [8:0][31:0] ot;
        logic [31:0] px;
        int nv = 0, nfd = 0, bad = 0;
        do_reset();
        for (int k = 0; k < 28 * 28; k++) begin
            case (k)
                0:       px = 32'h401c28f6;
                1:       px = 32'h40839581;
                2:       px = 32'h40c722d1;
                default: px = $urandom;
            endcase
            step(1'b1, 1'b1, px, want, ov, ofd, ot);
            if (ov === 1'b1) nv++;
            if (ofd === 1'b1) nfd++;
            if (ov !== want.v || ofd !== want.fd || (want.chk && ot !== want.t)) begin
                bad++;
                if (bad <= 4)
                    $display("FAIL xp_window k=%0d got v=%b fd=%b t=%h want v=%b fd=%b t=%h",
                             k, ov, ofd, ot, want.v, want.fd, want.t);
            end
            if (k == 2 * 28 + 2) begin
                checks++;
                if (ot[0] !== 32'h401c28f6 || ot[1] !== 32'h40839581 || ot[2] !== 32'h40c722d1) begin
                    errors++;
                    $display("FAIL xp_float got %h %h %h want 401c28f6 40839581 40c722d1",
                             ot[0], ot[1], ot[2]);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL xp_windows got %0d bad want 0", bad);
        end
        checks++;
        if (nv != 676 || nfd != 1) begin
            errors++;
            $display("FAIL xp_counts got v=%0d fd=%0d want v=676 fd=1", nv, nfd);
        end
    endtask

    initial begin
        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        init_model();
        test_reset();
        test_continuous();
        test_gapped();
        test_row_wrap();
        test_back_to_back();
        test_reset_mid();
        test_transparency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
